// File: rtl/ser9_rx_if.sv
// Bus bundle for the 9-bit serial receiver: serial line in, word/status out,
// plus the consumer acknowledge.
interface ser9_rx_if;
    logic       serial_in;
    logic       rd_ack;
    logic [8:0] data_out;
    logic       word_valid;
    logic       busy;
    logic       framing_err;
    logic       overrun;

    // Receiver side
    modport slave (
        input  serial_in,
        input  rd_ack,
        output data_out,
        output word_valid,
        output busy,
        output framing_err,
        output overrun
    );

    // Line driver / word consumer side
    modport master (
        output serial_in,
        output rd_ack,
        input  data_out,
        input  word_valid,
        input  busy,
        input  framing_err,
        input  overrun
    );
endinterface

// File: rtl/ser9_rx.sv
// ser9_rx: asynchronous serial receiver with start bit, nine data bits
// (LSB first, bit 8 being a parity bit passed through untouched) and one stop
// bit. Sampling is at mid-bit, BIT_TICKS clocks per bit. A received word is
// held until acknowledged; a good word arriving while one is still held is
// dropped and flagged as overrun.
module ser9_rx #(
    parameter int unsigned BIT_TICKS = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    ser9_rx_if.slave bus
);

    localparam int unsigned CW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          sync1_q, sync2_q;
    logic          s_in;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    sh_q, sh_d;
    logic [8:0]    dout_q, dout_d;
    logic          wv_q, wv_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          good;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_in = sync2_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            wv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            wv_q    <= wv_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame sequencing, bit sampling and word hand-off to the consumer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        wv_d    = wv_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        good    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!s_in) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = s_in ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {s_in, sh_q[8:1]};
                    if (idx_q == 4'd8) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (s_in) begin
                        good = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An acknowledge in the completion cycle frees the holding register,
        // so the new word is loaded rather than dropped.
        if (good && wv_q && !bus.rd_ack) begin
            ovr_d = 1'b1;
        end else if (bus.rd_ack && wv_q) begin
            wv_d  = 1'b0;
            ovr_d = 1'b0;
        end
        if (good && (!wv_q || bus.rd_ack)) begin
            dout_d = sh_q;
            wv_d   = 1'b1;
        end
    end

    assign bus.data_out    = dout_q;
    assign bus.word_valid  = wv_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.framing_err = ferr_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_ser9_rx.sv
// Self-checking bench for ser9_rx (BIT_TICKS=16). Expected word loads and
// framing errors are queued by the stimulus; a monitor forked from the main
// process pops and compares them when the DUT presents them.
module tb_ser9_rx;

    localparam int BT = 16;

    typedef struct packed {
        logic       is_ferr;
        logic [8:0] data;
    } ev_t;

    logic clk;
    logic rst_n;
    ser9_rx_if bus();

    ev_t exp_q[$];
    int  n_checks;
    int  n_fail;

    ser9_rx #(.BIT_TICKS(BT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 bus.rd_ack = 1'b1;
        @(posedge clk);
        #1 bus.rd_ack = 1'b0;
        check("ack_clears_valid", 32'(bus.word_valid), 0);
        check("ack_clears_overrun", 32'(bus.overrun), 0);
    endtask

    // mode: 0 no timing checks, 1 load, 2 framing error, 3 dropped (overrun),
    // 4 load with rd_ack in completion cycle. rst_k >= 0 aborts via reset.
    task automatic send_frame(input logic [8:0] d, input logic stop_b,
                              input int mode, input int rst_k);
        logic [8:0] dd;
        int b;
        dd = d;
        for (int k = 0; k < 11 * BT; k++) begin
            @(posedge clk);
            #1;
            b = k / BT;
            if (b == 0)       bus.serial_in = 1'b0;
            else if (b == 10) bus.serial_in = stop_b;
            else              bus.serial_in = dd[b-1];

            if (k == rst_k) begin
                bus.serial_in = 1'b1;
                rst_n = 1'b0;
                #1;
                check("rst_mid_data_out", 32'(bus.data_out), 0);
                check("rst_mid_valid", 32'(bus.word_valid), 0);
                check("rst_mid_busy", 32'(bus.busy), 0);
                check("rst_mid_ferr", 32'(bus.framing_err), 0);
                check("rst_mid_overrun", 32'(bus.overrun), 0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end

            if (mode == 4 && k == 170) bus.rd_ack = 1'b1;

            if (k == 170) begin
                if (mode == 1) begin
                    check("lat_valid_before", 32'(bus.word_valid), 0);
                    check("busy_during_stop", 32'(bus.busy), 1);
                end
            end
            if (k == 171) begin
                case (mode)
                    1: begin
                        check("lat_valid_rise", 32'(bus.word_valid), 1);
                        check("load_data", 32'(bus.data_out), 32'(d));
                        check("busy_after_frame", 32'(bus.busy), 0);
                        check("no_ferr_good", 32'(bus.framing_err), 0);
                    end
                    2: begin
                        check("ferr_pulse", 32'(bus.framing_err), 1);
                        check("ferr_no_valid", 32'(bus.word_valid), 0);
                    end
                    3: begin
                        check("overrun_set", 32'(bus.overrun), 1);
                        check("drop_valid_held", 32'(bus.word_valid), 1);
                    end
                    4: begin
                        bus.rd_ack = 1'b0;
                        check("ackload_valid", 32'(bus.word_valid), 1);
                        check("ackload_data", 32'(bus.data_out), 32'(d));
                        check("ackload_no_overrun", 32'(bus.overrun), 0);
                    end
                    default: ;
                endcase
            end
            if (k == 172 && mode == 2) begin
                check("ferr_one_cycle", 32'(bus.framing_err), 0);
            end
        end
        @(posedge clk);
        #1 bus.serial_in = 1'b1;
    endtask

    task automatic push_load(input logic [8:0] d);
        ev_t e;
        e.is_ferr = 1'b0;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_ferr();
        ev_t e;
        e.is_ferr = 1'b1;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic is_ferr, input logic [8:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", {22'd0, is_ferr, d}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_ferr), 32'(e.is_ferr));
            if (!is_ferr) check("event_data", 32'(d), 32'(e.data));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.serial_in = 1'b1;
        bus.rd_ack = 1'b0;

        fork
            begin : monitor
                logic       pv, pf, pr;
                logic [8:0] pd;
                pv = 1'b0; pf = 1'b0; pr = 1'b0; pd = '0;
                forever begin
                    @(negedge clk);
                    if (rst_n && pr) begin
                        if (bus.word_valid && (!pv || bus.data_out != pd))
                            observe(1'b0, bus.data_out);
                        if (bus.framing_err) begin
                            if (pf) check("ferr_width", 32'd2, 32'd1);
                            else    observe(1'b1, 9'd0);
                        end
                    end
                    pv = bus.word_valid;
                    pf = bus.framing_err;
                    pd = bus.data_out;
                    pr = rst_n;
                end
            end
        join_none

        // Reset state
        wait_cycles(3);
        check("reset_data_out", 32'(bus.data_out), 0);
        check("reset_valid", 32'(bus.word_valid), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_ferr", 32'(bus.framing_err), 0);
        check("reset_overrun", 32'(bus.overrun), 0);
        rst_n = 1'b1;
        wait_cycles(5);

        // Good frame 0x1A5
        push_load(9'h1A5);
        send_frame(9'h1A5, 1'b1, 1, -1);
        wait_cycles(10);
        ack_pulse();
        wait_cycles(10);

        // Start-bit glitch
        bus.serial_in = 1'b0;
        wait_cycles(6);
        bus.serial_in = 1'b1;
        wait_cycles(30);
        check("glitch_busy", 32'(bus.busy), 0);
        check("glitch_valid", 32'(bus.word_valid), 0);

        // Framing error on 0x0FF
        push_ferr();
        send_frame(9'h0FF, 1'b0, 2, -1);
        wait_cycles(30);
        check("ferr_data_kept", 32'(bus.data_out), 32'h1A5);
        check("ferr_valid_low", 32'(bus.word_valid), 0);
        check("ferr_busy_low", 32'(bus.busy), 0);

        // Overrun: 0x001 then 0x100 without acknowledge
        push_load(9'h001);
        send_frame(9'h001, 1'b1, 1, -1);
        wait_cycles(10);
        send_frame(9'h100, 1'b1, 3, -1);
        wait_cycles(10);
        check("ovr_data_kept", 32'(bus.data_out), 32'h001);
        check("ovr_flag", 32'(bus.overrun), 1);
        ack_pulse();
        wait_cycles(10);

        // Acknowledge coinciding with completion of the second frame
        push_load(9'h001);
        send_frame(9'h001, 1'b1, 1, -1);
        wait_cycles(10);
        push_load(9'h100);
        send_frame(9'h100, 1'b1, 4, -1);
        wait_cycles(10);
        check("ackload_final_data", 32'(bus.data_out), 32'h100);

        // Reset during bit 4, then a clean 0x0AA
        send_frame(9'h155, 1'b1, 0, 5 * BT + 5);
        wait_cycles(40);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_valid", 32'(bus.word_valid), 0);
        push_load(9'h0AA);
        send_frame(9'h0AA, 1'b1, 1, -1);
        wait_cycles(30);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ser9_rx.md
SER9_RX -- requirements
Module: ser9_rx

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 16, meaning clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port serial_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rd_ack  input  1  consumer acknowledge, one-cycle pulse, clears word_valid.
REQ-006 SHALL have port data_out  output  9  last good word; bit 8 is the received parity bit; this is the 9-bit input of the downstream parity checker.
REQ-007 SHALL have port word_valid  output  1  data_out holds an unconsumed word.
REQ-008 SHALL have port busy  output  1  frame reception in progress (any state except IDLE).
REQ-009 SHALL have port framing_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun  output  1  sticky flag: a good word was dropped because word_valid was still high.

Function
REQ-011 SHALL pass serial_in through a 2-flop synchronizer; all timing below refers to the synchronized signal, s_in.
REQ-012 SHALL implement the states IDLE, START, DATA and STOP, with a bit-tick counter of ceil(log2(BIT_TICKS)) bits and a 4-bit bit index.
REQ-013 IDLE -> START SHALL occur in the cycle s_in is sampled low; call that cycle t0.
REQ-014 In START, at t0+BIT_TICKS/2, if s_in is low the block SHALL go to DATA; otherwise it SHALL return to IDLE (glitch reject) with no flag raised.
REQ-015 In DATA, the block SHALL sample bit i (i = 0..8, LSB first) at t0+BIT_TICKS/2+(i+1)*BIT_TICKS into a 9-bit shift register, then go to STOP after bit 8.
REQ-016 In STOP, at t0+BIT_TICKS/2+10*BIT_TICKS the block SHALL sample s_in and return to IDLE in the next cycle.
REQ-017 A high stop sample SHALL constitute a good word; a low stop sample SHALL pulse framing_err for exactly 1 cycle and discard the word.
REQ-018 On a good word with word_valid low, the block SHALL load data_out and set word_valid in the cycle after the stop sample.
REQ-019 On a good word with word_valid high and rd_ack low, the block SHALL drop the word, leave data_out unchanged and set overrun.
REQ-020 On a good word in the same cycle as rd_ack, acknowledge SHALL take precedence: the block loads the new word, word_valid stays high and overrun is not set.
REQ-021 rd_ack alone SHALL clear word_valid and overrun in the next cycle; rd_ack while word_valid is low SHALL be ignored.
REQ-022 data_out SHALL remain stable while word_valid is high, and SHALL otherwise change only on a good-word load.
REQ-023 The block SHALL do no parity computation; bit 8 is passed through unmodified.
REQ-024 After returning to IDLE, a low s_in SHALL start a new frame immediately, with no extra idle cycles required.

Reset
REQ-025 While rst_n is low, the block SHALL immediately force: state IDLE, counters 0, shift register 0, synchronizer flops 1, data_out 9'h000, and word_valid, busy, framing_err and overrun all 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no word loaded and no flag raised; after release the block SHALL wait for a fresh falling edge.

Verification (BIT_TICKS=16)
REQ-027 Frame start 0, bits LSB-first of 9'h1A5, stop 1 -> data_out=9'h1A5, word_valid rises 1 cycle after the stop sample, busy low afterwards, framing_err=0.
REQ-028 serial_in low for 6 cycles, then high -> back to IDLE with busy low, word_valid=0 and framing_err=0.
REQ-029 Frame 9'h0FF with stop bit 0 -> framing_err high for exactly 1 cycle, word_valid=0, data_out unchanged.
REQ-030 Two good frames 9'h001 then 9'h100 with no rd_ack -> data_out=9'h001, overrun=1; then rd_ack -> word_valid=0 and overrun=0 on the next cycle.
REQ-031 rd_ack in the same cycle as the second frame's completion -> data_out=9'h100, word_valid=1, overrun=0.
REQ-032 rst_n pulsed low during bit 4 of a frame -> all outputs 0 immediately; the next clean frame 9'h0AA is received correctly.
